// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the instruction/data memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_LATENCY,
        ST_RESP
    } state_e;

    typedef enum logic {
        SEL_INST,
        SEL_DATA
    } sel_e;

    localparam int unsigned CNT_W     = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port 32-bit word RAM with byte-lane writes and a registered read port.
module mem_resp_ram #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter              INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [3:0]            strb_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (strb_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder serving fetch, load and store handshakes from one RAM,
// with programmable or LFSR-randomised accept/response latencies.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned REQ_DELAY    = 0,
    parameter int unsigned RESP_DELAY   = 1,
    parameter bit          RANDOM_DELAY = 1'b0,
    parameter              INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready,
    output logic [31:0] stall_cnt
);

    localparam int unsigned RESP_FIX = (RESP_DELAY == 0) ? 1 : RESP_DELAY;

    state_e                state_q;
    sel_e                  sel_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  inst_rdy_q, mem_rdy_q;
    logic                  inst_vld_q, data_vld_q;
    logic                  out_inst_q, out_data_q;
    logic [15:0]           lfsr_q;
    logic [31:0]           stall_q;

    logic [CNT_W-1:0]      req_dly, resp_dly;
    logic                  data_req, sel_vld, sel_rdy, resp_rdy, hs, is_store, stall;
    logic [ADDR_WIDTH-1:0] req_idx, ram_addr;
    logic                  ram_we, ram_rd;
    logic [31:0]           ram_rdata;
    logic                  unused_addr_bits;

    always_comb begin
        if (RANDOM_DELAY) begin
            req_dly  = CNT_W'(lfsr_q[2:0]);
            resp_dly = (lfsr_q[2:0] == 3'd0) ? CNT_W'(1) : CNT_W'(lfsr_q[2:0]);
        end else begin
            req_dly  = CNT_W'(REQ_DELAY);
            resp_dly = CNT_W'(RESP_FIX);
        end
    end

    always_comb begin
        data_req = MemRead | MemWrite;
        sel_vld  = (sel_q == SEL_DATA) ? data_req : Inst_Req_Valid;
        sel_rdy  = (sel_q == SEL_DATA) ? mem_rdy_q : inst_rdy_q;
        resp_rdy = (sel_q == SEL_DATA) ? Read_data_Ready : Inst_Ready;
        hs       = (state_q == ST_ACCEPT) && sel_rdy && sel_vld;
        is_store = (sel_q == SEL_DATA) && MemWrite;
        req_idx  = (sel_q == SEL_DATA) ? Address[ADDR_WIDTH+1:2] : PC[ADDR_WIDTH+1:2];
        ram_addr = (state_q == ST_ACCEPT) ? req_idx : idx_q;
        ram_we   = !rst && hs && is_store;
        // A 1-cycle response reads straight off the request bus in the accept cycle.
        ram_rd   = !rst && ((hs && !is_store && resp_dly == CNT_W'(1)) ||
                            (state_q == ST_LATENCY && cnt_q == CNT_W'(1)));
        stall    = ((state_q == ST_ACCEPT) && !hs) || ((state_q == ST_RESP) && !resp_rdy);
    end

    assign unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                                Address[31:ADDR_WIDTH+2], Address[1:0]};

    mem_resp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_we | ram_rd),
        .we_i    (ram_we),
        .strb_i  (Write_strb),
        .addr_i  (ram_addr),
        .wdata_i (Write_data),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_INST;
            cnt_q      <= '0;
            idx_q      <= '0;
            inst_rdy_q <= 1'b0;
            mem_rdy_q  <= 1'b0;
            inst_vld_q <= 1'b0;
            data_vld_q <= 1'b0;
            out_inst_q <= 1'b0;
            out_data_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (data_req) begin
                        sel_q     <= SEL_DATA;
                        cnt_q     <= req_dly;
                        mem_rdy_q <= (req_dly == '0);
                        state_q   <= ST_ACCEPT;
                    end else if (Inst_Req_Valid) begin
                        sel_q      <= SEL_INST;
                        cnt_q      <= req_dly;
                        inst_rdy_q <= (req_dly == '0);
                        state_q    <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (!sel_vld) begin
                        inst_rdy_q <= 1'b0;
                        mem_rdy_q  <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (hs) begin
                        inst_rdy_q <= 1'b0;
                        mem_rdy_q  <= 1'b0;
                        idx_q      <= req_idx;
                        if (is_store) begin
                            state_q <= ST_IDLE;
                        end else if (resp_dly == CNT_W'(1)) begin
                            inst_vld_q <= (sel_q == SEL_INST);
                            data_vld_q <= (sel_q == SEL_DATA);
                            out_inst_q <= (sel_q == SEL_INST);
                            out_data_q <= (sel_q == SEL_DATA);
                            state_q    <= ST_RESP;
                        end else begin
                            cnt_q   <= resp_dly - CNT_W'(1);
                            state_q <= ST_LATENCY;
                        end
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            inst_rdy_q <= (sel_q == SEL_INST);
                            mem_rdy_q  <= (sel_q == SEL_DATA);
                        end
                    end
                end
                ST_LATENCY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        inst_vld_q <= (sel_q == SEL_INST);
                        data_vld_q <= (sel_q == SEL_DATA);
                        out_inst_q <= (sel_q == SEL_INST);
                        out_data_q <= (sel_q == SEL_DATA);
                        state_q    <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_rdy) begin
                        inst_vld_q <= 1'b0;
                        data_vld_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q  <= LFSR_SEED;
            stall_q <= '0;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
            if (stall) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    // The RAM read register is shared; each output shows it only once its channel read it.
    assign Instruction     = out_inst_q ? ram_rdata : '0;
    assign Read_data       = out_data_q ? ram_rdata : '0;
    assign Inst_Req_Ready  = inst_rdy_q;
    assign Mem_Req_Ready   = mem_rdy_q;
    assign Inst_Valid      = inst_vld_q;
    assign Read_data_Valid = data_vld_q;
    assign stall_cnt       = stall_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance 0 fixed 0/1 delays, 1 fixed 2/4 delays, 2 random delays.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  who;
    logic [31:0] pc, addr, wdata;
    logic [3:0]  strb;
    logic        iv, irdy, mw, mr, drdy;

    logic        ir_a [3];
    logic        ivl_a[3];
    logic        mrr_a[3];
    logic        dvl_a[3];
    logic [31:0] ins_a[3];
    logic [31:0] rd_a [3];
    logic [31:0] st_a [3];

    logic        ir, ivld, mrr, dvld;
    logic [31:0] ins, rdat, stall;

    assign ir    = ir_a[who];
    assign ivld  = ivl_a[who];
    assign mrr   = mrr_a[who];
    assign dvld  = dvl_a[who];
    assign ins   = ins_a[who];
    assign rdat  = rd_a[who];
    assign stall = st_a[who];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int unsigned RQ  = (k == 1) ? 2 : 0;
        localparam int unsigned RS  = (k == 1) ? 4 : 1;
        localparam bit          RND = (k == 2);
        mem_responder #(
            .ADDR_WIDTH   (12),
            .REQ_DELAY    (RQ),
            .RESP_DELAY   (RS),
            .RANDOM_DELAY (RND),
            .INIT_FILE    ("")
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .PC              (pc),
            .Inst_Req_Valid  (iv && who == 2'(k)),
            .Inst_Req_Ready  (ir_a[k]),
            .Instruction     (ins_a[k]),
            .Inst_Valid      (ivl_a[k]),
            .Inst_Ready      (irdy && who == 2'(k)),
            .Address         (addr),
            .MemWrite        (mw && who == 2'(k)),
            .Write_data      (wdata),
            .Write_strb      (strb),
            .MemRead         (mr && who == 2'(k)),
            .Mem_Req_Ready   (mrr_a[k]),
            .Read_data       (rd_a[k]),
            .Read_data_Valid (dvl_a[k]),
            .Read_data_Ready (drdy && who == 2'(k)),
            .stall_cnt       (st_a[k])
        );
    end

    int total = 0;
    int bad   = 0;
    bit dual_seen = 1'b0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ivl_a[k] && dvl_a[k]) dual_seen <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        addr = a; wdata = d; strb = s; mw = 1'b1; n = 0;
        tick();
        while (!mrr && n < 40) begin tick(); n++; end
        chk("store_ready", 32'(mrr), 32'd1);
        tick();
        mw = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d);
        int n;
        addr = a; mr = 1'b1; n = 0;
        tick();
        while (!mrr && n < 40) begin tick(); n++; end
        chk("load_ready", 32'(mrr), 32'd1);
        tick();
        mr = 1'b0; n = 0;
        while (!dvld && n < 40) begin tick(); n++; end
        chk("load_valid", 32'(dvld), 32'd1);
        d = rdat; drdy = 1'b1;
        tick();
        drdy = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, output logic [31:0] d);
        int n;
        pc = a; iv = 1'b1; n = 0;
        tick();
        while (!ir && n < 40) begin tick(); n++; end
        chk("fetch_ready", 32'(ir), 32'd1);
        tick();
        iv = 1'b0; n = 0;
        while (!ivld && n < 40) begin tick(); n++; end
        chk("fetch_valid", 32'(ivld), 32'd1);
        d = ins; irdy = 1'b1;
        tick();
        irdy = 1'b0;
    endtask

    logic [31:0] model [64];
    logic [31:0] d, a, wd, s0;
    logic [3:0]  s;
    int unsigned idx, hi, op;

    initial begin
        rst = 1'b1; who = 2'd0;
        pc = '0; addr = '0; wdata = '0; strb = '0;
        iv = 1'b0; irdy = 1'b0; mw = 1'b0; mr = 1'b0; drdy = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // reset state
        chk("rst_inst_ready", 32'(ir), 32'd0);
        chk("rst_inst_valid", 32'(ivld), 32'd0);
        chk("rst_mem_ready", 32'(mrr), 32'd0);
        chk("rst_data_valid", 32'(dvld), 32'd0);
        chk("rst_instruction", ins, 32'd0);
        chk("rst_read_data", rdat, 32'd0);
        chk("rst_stall", stall, 32'd0);

        // minimum-latency fetch
        do_store(32'h10, 32'h00500093, 4'hF);
        pc = 32'h10; iv = 1'b1;
        tick();
        chk("t1_ready_t1", 32'(ir), 32'd1);
        chk("t1_novalid_t1", 32'(ivld), 32'd0);
        tick();
        iv = 1'b0;
        chk("t1_ready_drop", 32'(ir), 32'd0);
        chk("t1_valid_t2", 32'(ivld), 32'd1);
        chk("t1_instr", ins, 32'h00500093);
        irdy = 1'b1;
        tick();
        irdy = 1'b0;
        chk("t1_valid_drop", 32'(ivld), 32'd0);

        // byte-lane store
        do_store(32'h20, 32'h11223344, 4'hF);
        do_store(32'h20, 32'h00AB0000, 4'b0100);
        do_load(32'h20, d);
        chk("t2_merge", d, 32'h11AB3344);

        // simultaneous load and fetch: data channel wins
        addr = 32'h20; mr = 1'b1; pc = 32'h10; iv = 1'b1;
        tick();
        chk("t3_mem_ready", 32'(mrr), 32'd1);
        chk("t3_inst_held", 32'(ir), 32'd0);
        tick();
        mr = 1'b0;
        chk("t3_load_valid", 32'(dvld), 32'd1);
        chk("t3_load_data", rdat, 32'h11AB3344);
        chk("t3_inst_held_resp", 32'(ir), 32'd0);
        chk("t3_no_inst_valid", 32'(ivld), 32'd0);
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        chk("t3_inst_held_idle", 32'(ir), 32'd0);
        tick();
        chk("t3_inst_ready", 32'(ir), 32'd1);
        tick();
        iv = 1'b0;
        chk("t3_inst_valid", 32'(ivld), 32'd1);
        chk("t3_instr", ins, 32'h00500093);
        irdy = 1'b1;
        tick();
        irdy = 1'b0;

        // response backpressure
        addr = 32'h20; mr = 1'b1;
        tick();
        tick();
        mr = 1'b0;
        s0 = stall;
        chk("t4_valid0", 32'(dvld), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_valid_hold", 32'(dvld), 32'd1);
            chk("t4_data_hold", rdat, 32'h11AB3344);
        end
        chk("t4_stall_plus5", stall, s0 + 32'd5);
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        chk("t4_valid_drop", 32'(dvld), 32'd0);
        chk("t4_stall_final", stall, s0 + 32'd5);

        // slow instance: aborted store, aborted load, then a normal fetch
        who = 2'd1;
        do_store(32'h20, 32'hCAFEF00D, 4'hF);
        do_store(32'h24, 32'h12345678, 4'hF);
        addr = 32'h24; wdata = 32'hFFFFFFFF; strb = 4'hF; mw = 1'b1;
        tick();
        chk("t6_store_not_ready", 32'(mrr), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; mw = 1'b0;
        chk("t6_store_abort_ready", 32'(mrr), 32'd0);
        do_load(32'h24, d);
        chk("t6_store_not_written", d, 32'h12345678);

        addr = 32'h20; mr = 1'b1;
        tick();
        chk("t6_ready_c1", 32'(mrr), 32'd0);
        tick();
        chk("t6_ready_c2", 32'(mrr), 32'd0);
        tick();
        chk("t6_ready_c3", 32'(mrr), 32'd1);
        tick();
        mr = 1'b0;
        chk("t6_in_latency", 32'(dvld), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_dvalid", 32'(dvld), 32'd0);
        chk("t6_rst_ivalid", 32'(ivld), 32'd0);
        chk("t6_rst_mready", 32'(mrr), 32'd0);
        repeat (3) tick();
        chk("t6_no_late_valid", 32'(dvld), 32'd0);

        pc = 32'h20; iv = 1'b1;
        tick();
        chk("t6_f_ready_c1", 32'(ir), 32'd0);
        tick();
        chk("t6_f_ready_c2", 32'(ir), 32'd0);
        tick();
        chk("t6_f_ready_c3", 32'(ir), 32'd1);
        tick();
        iv = 1'b0;
        tick();
        tick();
        chk("t6_f_valid_c6", 32'(ivld), 32'd0);
        tick();
        chk("t6_f_valid_c7", 32'(ivld), 32'd1);
        chk("t6_f_instr", ins, 32'hCAFEF00D);
        irdy = 1'b1;
        tick();
        irdy = 1'b0;

        // random-delay instance against a scoreboard
        who = 2'd2;
        for (int i = 0; i < 64; i++) begin
            model[i] = $urandom;
            do_store(32'(i * 4), model[i], 4'hF);
        end
        for (int n = 0; n < 1000; n++) begin
            op  = $urandom_range(0, 2);
            idx = $urandom_range(0, 63);
            hi  = $urandom_range(0, 15);
            a   = (32'(hi) << 14) | (32'(idx) << 2);
            if (op == 0) begin
                wd = $urandom;
                s  = 4'($urandom_range(0, 15));
                do_store(a, wd, s);
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end else if (op == 1) begin
                do_load(a, d);
                chk("rnd_load", d, model[idx]);
            end else begin
                do_fetch(a | 32'($urandom_range(0, 3)), d);
                chk("rnd_fetch", d, model[idx]);
            end
        end
        tick();
        chk("no_dual_valid", 32'(dual_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
